// File: rtl/connect4_move_input.sv
// Connect-4 player input front end: button conditioning, column cursor, turn control and place commands.
// Optional build macro CONNECT4_COL_FULL_CHECK_EN adds per-column fill tracking and the col_full_err pulse.
module connect4_move_input #(
    parameter int DEB_CYCLES  = 16,
    parameter int PLACE_HOLD  = 2,
    parameter int GAP_CYCLES  = 3,
    parameter int CURSOR_INIT = 3
) (
    input  logic       CLK,
    input  logic       NRST,
    input  logic       start,
    input  logic       g_left,
    input  logic       g_right,
    input  logic       g_drop,
    input  logic       o_left,
    input  logic       o_right,
    input  logic       o_drop,
    input  logic [1:0] result,
    output logic [3:0] G,
    output logic [3:0] O,
    output logic [2:0] cursor,
    output logic       turn,
`ifdef CONNECT4_COL_FULL_CHECK_EN
    output logic       col_full_err,
`endif
    output logic       game_over
);

    localparam int DW       = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_MAX = (PLACE_HOLD > GAP_CYCLES) ? PLACE_HOLD : GAP_CYCLES;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(PLACE_HOLD - 1);
    localparam logic [HW-1:0] GAP_LAST  = HW'(GAP_CYCLES - 1);
    localparam logic [2:0]    CUR_RST   = 3'(CURSOR_INIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MOVE,
        S_ISSUE,
        S_GAP,
        S_DONE
    } state_t;

    function automatic logic [3:0] place_cmd(input logic [2:0] c);
        return {1'b1, c};
    endfunction

    // Button order: [0] g_left [1] g_right [2] g_drop [3] o_left [4] o_right [5] o_drop
    logic [5:0]    btn_raw;
    logic [5:0]    sync_p0;
    logic [5:0]    sync_p1;
    logic [5:0]    level_p2;
    logic [5:0]    evt_p2;
    logic [DW-1:0] deb_cnt [6];

    assign btn_raw = {o_drop, o_right, o_left, g_drop, g_right, g_left};

    // p0/p1: two-flop synchroniser; p2: debounced level and its rising-edge pulse
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            level_p2 <= '0;
            evt_p2   <= '0;
            for (int i = 0; i < 6; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            evt_p2  <= '0;
            for (int i = 0; i < 6; i++) begin
                if (sync_p1[i] == level_p2[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i]  <= '0;
                    level_p2[i] <= sync_p1[i];
                    evt_p2[i]   <= sync_p1[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    logic       ev_left;
    logic       ev_right;
    logic       ev_drop;
    logic [2:0] cur_next;
    logic       drop_ok;

    state_t        state;
    logic [HW-1:0] hcnt;
    logic          relaunch;

`ifdef CONNECT4_COL_FULL_CHECK_EN
    logic [2:0] col;
    logic [3:0] fill [8];
`endif

    // The idle player's events are simply not looked at, so they are lost rather than queued.
    always_comb begin
        ev_left  = turn ? evt_p2[3] : evt_p2[0];
        ev_right = turn ? evt_p2[4] : evt_p2[1];
        ev_drop  = turn ? evt_p2[5] : evt_p2[2];
        cur_next = cursor;
        if (ev_left && !ev_right) begin
            cur_next = cursor - 3'd1;
        end else if (ev_right && !ev_left) begin
            cur_next = cursor + 3'd1;
        end
`ifdef CONNECT4_COL_FULL_CHECK_EN
        drop_ok = (fill[cursor] != 4'd8);
`else
        drop_ok = 1'b1;
`endif
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state     <= S_IDLE;
            G         <= '0;
            O         <= '0;
            cursor    <= CUR_RST;
            turn      <= 1'b0;
            game_over <= 1'b0;
            hcnt      <= '0;
            relaunch  <= 1'b0;
`ifdef CONNECT4_COL_FULL_CHECK_EN
            col          <= '0;
            col_full_err <= 1'b0;
            for (int c = 0; c < 8; c++) begin
                fill[c] <= '0;
            end
`endif
        end else begin
`ifdef CONNECT4_COL_FULL_CHECK_EN
            col_full_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    G <= '0;
                    O <= '0;
                    if (start || relaunch) begin
                        state    <= S_WAIT_MOVE;
                        turn     <= 1'b0;
                        cursor   <= CUR_RST;
                        relaunch <= 1'b0;
`ifdef CONNECT4_COL_FULL_CHECK_EN
                        for (int c = 0; c < 8; c++) begin
                            fill[c] <= '0;
                        end
`endif
                    end
                end
                S_WAIT_MOVE: begin
                    // A drop takes priority and uses the cursor as it stood before any move.
                    if (ev_drop && drop_ok) begin
                        state <= S_ISSUE;
                        hcnt  <= '0;
`ifdef CONNECT4_COL_FULL_CHECK_EN
                        col <= cursor;
`endif
                        if (turn) begin
                            O <= place_cmd(cursor);
                        end else begin
                            G <= place_cmd(cursor);
                        end
`ifdef CONNECT4_COL_FULL_CHECK_EN
                    end else if (ev_drop) begin
                        col_full_err <= 1'b1;
`endif
                    end else begin
                        cursor <= cur_next;
                    end
                end
                S_ISSUE: begin
                    if (hcnt == HOLD_LAST) begin
                        G     <= '0;
                        O     <= '0;
                        hcnt  <= '0;
                        state <= S_GAP;
`ifdef CONNECT4_COL_FULL_CHECK_EN
                        fill[col] <= fill[col] + 4'd1;
`endif
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                S_GAP: begin
                    if (hcnt == GAP_LAST) begin
                        hcnt <= '0;
                        if (result == 2'b00) begin
                            turn  <= ~turn;
                            state <= S_WAIT_MOVE;
                        end else begin
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                S_DONE: begin
                    G <= '0;
                    O <= '0;
                    if (start) begin
                        game_over <= 1'b0;
                        relaunch  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_connect4_move_input.sv
// Directed bench for connect4_move_input with a short debounce window (DEB_CYCLES = 4).
// Covers the CONNECT4_COL_FULL_CHECK_EN column-full path when that macro is defined.
module tb_connect4_move_input;

    localparam int DEB = 4;

    logic       CLK;
    logic       NRST;
    logic       start;
    logic [5:0] btn;
    logic [1:0] result;
    logic [3:0] G;
    logic [3:0] O;
    logic [2:0] cursor;
    logic       turn;
    logic       game_over;
`ifdef CONNECT4_COL_FULL_CHECK_EN
    logic       col_full_err;
`endif

    connect4_move_input #(
        .DEB_CYCLES (DEB),
        .PLACE_HOLD (2),
        .GAP_CYCLES (3),
        .CURSOR_INIT(3)
    ) dut (
        .CLK      (CLK),
        .NRST     (NRST),
        .start    (start),
        .g_left   (btn[0]),
        .g_right  (btn[1]),
        .g_drop   (btn[2]),
        .o_left   (btn[3]),
        .o_right  (btn[4]),
        .o_drop   (btn[5]),
        .result   (result),
        .G        (G),
        .O        (O),
        .cursor   (cursor),
        .turn     (turn),
`ifdef CONNECT4_COL_FULL_CHECK_EN
        .col_full_err(col_full_err),
`endif
        .game_over(game_over)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic [5:0] GL = 6'b000001, GR = 6'b000010, GD = 6'b000100;
    localparam logic [5:0] OL = 6'b001000, OR = 6'b010000, OD = 6'b100000;

    typedef struct {
        logic [5:0] mask;
        int         len;
        logic [2:0] exp_cursor;
        logic       exp_turn;
    } vec_t;

    vec_t vecs [13];

    int checks = 0;
    int errors = 0;

    int n_g = 0, n_o = 0, n_both = 0, n_err = 0;
    logic [3:0] last_g = '0, last_o = '0;

    always @(negedge CLK) begin
        if (G[3]) begin
            n_g    <= n_g + 1;
            last_g <= G;
        end
        if (O[3]) begin
            n_o    <= n_o + 1;
            last_o <= O;
        end
        if (G[3] && O[3]) n_both <= n_both + 1;
`ifdef CONNECT4_COL_FULL_CHECK_EN
        if (col_full_err) n_err <= n_err + 1;
`endif
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic press(input logic [5:0] m, input int len);
        btn = btn | m;
        repeat (len) @(negedge CLK);
        btn = btn & ~m;
        repeat (12) @(negedge CLK);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic run_vec(input int i);
        press(vecs[i].mask, vecs[i].len);
        check($sformatf("vec%0d_cursor", i), int'(cursor), int'(vecs[i].exp_cursor));
        check($sformatf("vec%0d_turn", i), int'(turn), int'(vecs[i].exp_turn));
    endtask

    int  g0, o0, e0;
    int  found;

    initial begin
        vecs[0]  = '{GR,      8, 3'd4, 1'b0};
        vecs[1]  = '{GR,      8, 3'd5, 1'b0};
        vecs[2]  = '{GL,      3, 3'd5, 1'b0};  // glitch shorter than the window
        vecs[3]  = '{OR,      8, 3'd5, 1'b0};  // not Orange's turn
        vecs[4]  = '{OR,      8, 3'd6, 1'b1};
        vecs[5]  = '{OR,      8, 3'd7, 1'b1};
        vecs[6]  = '{OR,      8, 3'd0, 1'b1};  // wrap 7 -> 0
        vecs[7]  = '{OL,      8, 3'd7, 1'b1};  // wrap 0 -> 7
        vecs[8]  = '{GR,      8, 3'd7, 1'b1};  // Green ignored
        vecs[9]  = '{OL | OR, 8, 3'd7, 1'b1};  // opposite moves cancel
        vecs[10] = '{OL,      3, 3'd7, 1'b1};
        vecs[11] = '{OL,      6, 3'd6, 1'b1};  // one event only
        vecs[12] = '{OD | OR, 8, 3'd6, 1'b0};  // drop wins at pre-move cursor

        btn    = '0;
        start  = 1'b0;
        result = 2'b00;
        NRST   = 1'b1;
        #3 NRST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_G", int'(G), 0);
        check("rst_O", int'(O), 0);
        check("rst_cursor", int'(cursor), 3);
        check("rst_turn", int'(turn), 0);
        check("rst_game_over", int'(game_over), 0);
        NRST = 1'b1;
        repeat (2) @(negedge CLK);

        press(GR, 8);
        check("idle_ignores_move", int'(cursor), 3);

        pulse_start();
        for (int i = 0; i < 4; i++) run_vec(i);

        g0 = n_g; o0 = n_o;
        press(GD, 8);
        check("drop1_G_cycles", n_g - g0, 2);
        check("drop1_G_value", int'(last_g), 13);
        check("drop1_O_cycles", n_o - o0, 0);
        check("drop1_turn", int'(turn), 1);
        check("drop1_cursor", int'(cursor), 5);
        check("drop1_G_idle", int'(G), 0);

        for (int i = 4; i < 13; i++) run_vec(i);
        check("drop2_O_value", int'(last_o), 14);

        result = 2'b01;
        g0 = n_g;
        press(GD, 8);
        check("win_game_over", int'(game_over), 1);
        check("win_G_value", int'(last_g), 14);
        check("win_G_cycles", n_g - g0, 2);
        check("win_turn_kept", int'(turn), 0);
        check("done_G", int'(G), 0);
        check("done_O", int'(O), 0);
        g0 = n_g; o0 = n_o;
        press(GD, 8);
        press(OD, 8);
        press(GR, 8);
        check("done_drops_ignored", (n_g - g0) + (n_o - o0), 0);
        check("done_cursor_frozen", int'(cursor), 6);
        check("done_still_over", int'(game_over), 1);
        result = 2'b00;
        pulse_start();
        check("restart_turn", int'(turn), 0);
        check("restart_cursor", int'(cursor), 3);
        check("restart_game_over", int'(game_over), 0);

        press(GR, 8);
        check("pre_rst_cursor", int'(cursor), 4);
        btn = btn | GD;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge CLK);
            if (G[3]) found = 1;
        end
        check("issue_seen_before_timeout", found, 1);
        NRST = 1'b0;
        #1;
        check("midissue_G_drop", int'(G), 0);
        check("midissue_cursor", int'(cursor), 3);
        btn = '0;
        repeat (12) @(negedge CLK);
        NRST = 1'b1;
        repeat (2) @(negedge CLK);
        press(GR, 8);
        check("post_rst_idle", int'(cursor), 3);
        check("post_rst_G", int'(G), 0);

`ifdef CONNECT4_COL_FULL_CHECK_EN
        pulse_start();
        press(GL, 8);
        check("full_cursor", int'(cursor), 2);
        g0 = n_g; o0 = n_o; e0 = n_err;
        for (int i = 0; i < 8; i++) press((i % 2 == 0) ? GD : OD, 8);
        check("full_issued_cycles", (n_g - g0) + (n_o - o0), 16);
        check("full_last_G", int'(last_g), 10);
        check("full_last_O", int'(last_o), 10);
        check("full_turn_after8", int'(turn), 0);
        check("full_no_err_yet", n_err - e0, 0);
        g0 = n_g; o0 = n_o;
        press(GD, 8);
        check("full9_no_cmd", (n_g - g0) + (n_o - o0), 0);
        check("full9_err_pulses", n_err - e0, 1);
        check("full9_turn", int'(turn), 0);
`endif

        check("never_both_buses", n_both, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
